ibex_data_bus_arbiter: RTL and testbench
========================================

// Module: ibex_data_bus_arbiter
// PURPOSE
//   Shares the core's single data-memory port (req/gnt/rvalid/err protocol) between two
//   hosts: host 0 = load-store unit, host 1 = secondary master (debug/DMA). Arbitrates
//   address phases (round-robin or fixed priority), honours a lock for split/misaligned
//   pairs, and routes each response back to its issuing host via an in-order owner FIFO.
// PARAMETERS
//   MaxOutstanding  2  response slots tracked; grants stall when all are in use (1..4)
//   FixedPrio       0  1: host 0 always wins; 0: round-robin, host 0 first after reset
// PORTS
//   clk_i           in   1   clock; all state updates on rising edge
//   rst_i           in   1   synchronous reset, active-high
//   h_req_i         in   2   per-host request; [0]=LSU, [1]=secondary
//   h_lock_i        in   2   per-host: keep bus for this host's next request too
//   h_addr_i        in   2x32 per-host word address
//   h_we_i          in   2   per-host write enable
//   h_be_i          in   2x4 per-host byte enables
//   h_wdata_i       in   2x32 per-host write data
//   h_gnt_o         out  2   per-host grant (one-hot or zero)
//   h_rvalid_o      out  2   per-host response valid (one-hot or zero)
//   h_err_o         out  2   per-host response error, valid with h_rvalid_o
//   h_rdata_o       out  32  read data, shared, valid with h_rvalid_o
//   data_req_o      out  1   device request
//   data_addr_o     out  32  device address
//   data_we_o       out  1   device write enable
//   data_be_o       out  4   device byte enables
//   data_wdata_o    out  32  device write data
//   data_gnt_i      in   1   device grant
//   data_rvalid_i   in   1   device response valid
//   data_err_i      in   1   device response error (only meaningful with rvalid)
//   data_rdata_i    in   32  device read data
//   unexp_rvalid_o  out  1   sticky: rvalid seen with no outstanding entry
// BEHAVIOUR
//   - Reset (rst_i=1): all outputs 0; FIFO empty, count=0; rr pointer->host 0; no
//     hold, no lock; unexp_rvalid_o cleared. Reset wins over any same-cycle event.
//   - Address phase: sel = held owner if hold_q, else locked owner if lock_q, else
//     arbitration winner among h_req_i. data_req_o = h_req_i[sel] && count<MaxOutstanding.
//     data_addr/we/be/wdata mux from host sel; 0 when data_req_o=0.
//   - Hold: data_req_o=1 and !data_gnt_i -> hold_q=1, owner frozen until granted
//     (device sees stable address phase). Owner dropping request while held clears hold.
//   - Grant: h_gnt_o[sel] = data_req_o && data_gnt_i (combinational, 0-cycle). On grant:
//     push sel into FIFO, hold_q<=0, lock_q<=h_lock_i[sel] (owner kept), rr pointer<=~sel.
//   - Lock: while lock_q, other host never wins; cleared by owner's next granted beat
//     with h_lock_i=0 or owner request low for a cycle with no hold.
//   - Arbitration (no hold/lock): single requester wins; both -> FixedPrio ? host 0 :
//     rr pointer host.
//   - Responses: data_rvalid_i && count>0 -> h_rvalid_o[head]=1, h_err_o[head]=data_err_i,
//     pop (same cycle, combinational route). rdata passed through unmodified.
//   - Full: count==MaxOutstanding -> data_req_o=0, no grants, even if rvalid same cycle
//     (slot frees next cycle). Empty: rvalid ignored, no host rvalid, unexp_rvalid_o<=1.
//   - Simultaneous grant+rvalid: push and pop both occur; count unchanged.
//   - Response latency: 0 cycles device->host; grant latency: 0 when unblocked.
// TESTING
//   1. LSU only, load at 0x100, gnt same cycle, rvalid+rdata=0xCAFEF00D next -> h_gnt_o=01,
//      h_rvalid_o=01, h_rdata_o=0xCAFEF00D, count back to 0.
//   2. Both request every cycle, gnt always 1, FixedPrio=0 -> grants 01,10,01,10; FixedPrio=1
//      -> 01 every cycle.
//   3. Host 1 requests, gnt low 3 cycles, host 0 requests meanwhile -> addr stays host 1's,
//      host 1 granted cycle 4, host 0 next.
//   4. Host 0 lock=1 on first beat (misaligned pair), host 1 requesting -> host 0 gets two
//      consecutive grants, host 1 granted only after second beat with lock=0.
//   5. MaxOutstanding=2, two grants, no rvalid -> data_req_o=0; rvalid cycle 3 -> request
//      reappears cycle 4; rvalid routing follows push order (01 then 10) with err=1 on 2nd.
//   6. rvalid with empty FIFO -> no h_rvalid_o, unexp_rvalid_o=1 until rst_i; rst_i mid-
//      transaction -> all outputs 0 next cycle, later rvalid flagged unexpected.

Source files
------------

// File: rtl/ibex_data_bus_arbiter.sv
// Two-host arbiter for the core data port: hold/lock aware address-phase selection
// and in-order response routing through a small owner FIFO.
//
// hold_q lock_q | meaning
// ------ ------ | --------------------------------------------------------------
//   0      0    | free: arbitrate among h_req_i each cycle
//   1      0    | held: address phase issued but not granted, owner frozen
//   0      1    | locked: owner keeps the bus for its next beat
//   1      1    | held while locked: stalled beat of a locked pair
module ibex_data_bus_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter bit FixedPrio      = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  h_req_i,
  input  logic [1:0]  h_lock_i,
  input  logic [63:0] h_addr_i,
  input  logic [1:0]  h_we_i,
  input  logic [7:0]  h_be_i,
  input  logic [63:0] h_wdata_i,
  output logic [1:0]  h_gnt_o,
  output logic [1:0]  h_rvalid_o,
  output logic [1:0]  h_err_o,
  output logic [31:0] h_rdata_o,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic        unexp_rvalid_o
);

  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt  = CW'(MaxOutstanding);
  localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);

  logic                      hold_q, hold_d;
  logic                      lock_q, lock_d;
  logic                      owner_q, owner_d;
  logic                      rr_q, rr_d;
  logic                      unexp_q, unexp_d;
  logic [MaxOutstanding-1:0] fifo_q;
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q;

  logic winner, sel, full, req_ok, grant, pop, head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // State register, including the owner FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q   <= 1'b0;
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      unexp_q  <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      unexp_q <= unexp_d;
      if (grant) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    hold_d  = hold_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unexp_d = unexp_q | (data_rvalid_i & (count_q == '0));
    if (grant) begin
      hold_d  = 1'b0;
      lock_d  = h_lock_i[sel];
      owner_d = sel;
      rr_d    = ~sel;
    end else if (req_ok) begin
      hold_d  = 1'b1;
      owner_d = sel;
    end else if (hold_q) begin
      if (!h_req_i[owner_q]) hold_d = 1'b0;
    end else if (lock_q && !h_req_i[owner_q]) begin
      lock_d = 1'b0;
    end
  end

  // Output logic; everything is forced low while reset is asserted
  always_comb begin
    case (h_req_i)
      2'b10:   winner = 1'b1;
      2'b11:   winner = FixedPrio ? 1'b0 : rr_q;
      default: winner = 1'b0;
    endcase
    sel    = (hold_q || lock_q) ? owner_q : winner;
    full   = (count_q == MaxCnt);
    req_ok = !rst_i && h_req_i[sel] && !full;
    grant  = req_ok && data_gnt_i;
    pop    = !rst_i && data_rvalid_i && (count_q != '0);
    head   = fifo_q[rd_ptr_q];

    data_req_o   = req_ok;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (req_ok) begin
      data_addr_o  = sel ? h_addr_i[63:32]  : h_addr_i[31:0];
      data_we_o    = h_we_i[sel];
      data_be_o    = sel ? h_be_i[7:4]      : h_be_i[3:0];
      data_wdata_o = sel ? h_wdata_i[63:32] : h_wdata_i[31:0];
    end

    h_gnt_o          = '0;
    h_gnt_o[sel]     = grant;
    h_rvalid_o       = '0;
    h_rvalid_o[head] = pop;
    h_err_o          = '0;
    h_err_o[head]    = pop && data_err_i;
    h_rdata_o        = rst_i ? '0 : data_rdata_i;
    unexp_rvalid_o   = unexp_q && !rst_i;
  end

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Directed bench for ibex_data_bus_arbiter: a per-cycle vector table plus two
// hand-written hold/lock release sequences; a FixedPrio=1 instance shares the inputs.
module tb_ibex_data_bus_arbiter;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [1:0]  e_err;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_unexp;
    logic [1:0]  e_fpg;
    logic        chk_fp;
  } vec_t;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'hAAAA_0001;
  localparam logic [31:0] W1 = 32'hBBBB_0002;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  h_req_i, h_lock_i, h_we_i;
  logic [63:0] h_addr_i, h_wdata_i;
  logic [7:0]  h_be_i;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;

  logic [1:0]  h_gnt_o, h_rvalid_o, h_err_o;
  logic [31:0] h_rdata_o, data_addr_o, data_wdata_o;
  logic        data_req_o, data_we_o, unexp_rvalid_o;
  logic [3:0]  data_be_o;

  logic [1:0]  fp_gnt, fp_rvalid, fp_err;
  logic [31:0] fp_rdata, fp_addr, fp_wdata;
  logic        fp_req, fp_we, fp_unexp;
  logic [3:0]  fp_be;

  int checks = 0;
  int errors = 0;
  int row = 0;
  vec_t vq[$];

  always #5 clk_i = ~clk_i;

  ibex_data_bus_arbiter #(.MaxOutstanding(2), .FixedPrio(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .h_req_i(h_req_i), .h_lock_i(h_lock_i),
    .h_addr_i(h_addr_i), .h_we_i(h_we_i), .h_be_i(h_be_i), .h_wdata_i(h_wdata_i),
    .h_gnt_o(h_gnt_o), .h_rvalid_o(h_rvalid_o), .h_err_o(h_err_o), .h_rdata_o(h_rdata_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
    .unexp_rvalid_o(unexp_rvalid_o)
  );

  ibex_data_bus_arbiter #(.MaxOutstanding(2), .FixedPrio(1'b1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i), .h_req_i(h_req_i), .h_lock_i(h_lock_i),
    .h_addr_i(h_addr_i), .h_we_i(h_we_i), .h_be_i(h_be_i), .h_wdata_i(h_wdata_i),
    .h_gnt_o(fp_gnt), .h_rvalid_o(fp_rvalid), .h_err_o(fp_err), .h_rdata_o(fp_rdata),
    .data_req_o(fp_req), .data_addr_o(fp_addr), .data_we_o(fp_we),
    .data_be_o(fp_be), .data_wdata_o(fp_wdata), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
    .unexp_rvalid_o(fp_unexp)
  );

  function automatic vec_t mk(
    input logic rst, input logic [1:0] req, input logic [1:0] lock, input logic gnt,
    input logic rv, input logic err, input logic [31:0] rdata,
    input logic [1:0] e_gnt, input logic [1:0] e_rv, input logic [1:0] e_err,
    input logic e_req, input logic [31:0] e_addr, input logic e_unexp,
    input logic [1:0] e_fpg, input logic chk_fp);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.gnt = gnt; v.rv = rv; v.err = err;
    v.rdata = rdata; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err; v.e_req = e_req;
    v.e_addr = e_addr; v.e_unexp = e_unexp; v.e_fpg = e_fpg; v.chk_fp = chk_fp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] lock,
                       input logic gnt, input logic rv, input logic err,
                       input logic [31:0] rdata);
    rst_i = rst; h_req_i = req; h_lock_i = lock; data_gnt_i = gnt;
    data_rvalid_i = rv; data_err_i = err; data_rdata_i = rdata;
  endtask

  // Address-side expectations follow from which host (if any) is presented
  task automatic chk_addr_phase(input logic e_req, input logic [31:0] e_addr);
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    e_we = 1'b0; e_be = 4'h0; e_wd = 32'h0;
    if (e_req && e_addr == A1) begin e_we = 1'b1; e_be = 4'hC; e_wd = W1; end
    else if (e_req)            begin e_we = 1'b0; e_be = 4'h3; e_wd = W0; end
    chk("data_req", 32'(data_req_o), 32'(e_req));
    chk("data_addr", data_addr_o, e_addr);
    chk("data_we", 32'(data_we_o), 32'(e_we));
    chk("data_be", 32'(data_be_o), 32'(e_be));
    chk("data_wdata", data_wdata_o, e_wd);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    row++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    h_addr_i  = {A1, A0};
    h_wdata_i = {W1, W0};
    h_we_i    = 2'b10;
    h_be_i    = 8'hC3;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    //          rst req    lock   g  rv er rdata          e_gnt  e_rv   e_err  rq addr unx fpg   cfp
    vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 1));
    vq.push_back(mk(1, 2'b11, 2'b00, 1, 1, 1, 32'h1234,     2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 1));
    // both hosts every cycle: round-robin alternates, fixed priority keeps host 0
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, A0, 0, 2'b01, 1));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 32'h0,        2'b10, 2'b01, 2'b00, 1, A1, 0, 2'b01, 1));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 32'h0,        2'b01, 2'b10, 2'b00, 1, A0, 0, 2'b01, 1));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 32'h0,        2'b10, 2'b01, 2'b00, 1, A1, 0, 2'b01, 1));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        2'b00, 2'b10, 2'b00, 0, 0,  0, 2'b00, 0));
    // single LSU load
    vq.push_back(mk(0, 2'b01, 2'b00, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, A0, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'hCAFEF00D, 2'b00, 2'b01, 2'b00, 0, 0,  0, 2'b00, 0));
    // host 1 held for three cycles while host 0 waits
    vq.push_back(mk(0, 2'b10, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 1, A1, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 1, A1, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 1, A1, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 1, A1, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b01, 2'b00, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, A0, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        2'b00, 2'b10, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 1, 32'h0,        2'b00, 2'b01, 2'b01, 0, 0,  0, 2'b00, 0));
    // locked pair from host 0; rr points at host 1 during the second beat
    vq.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, A0, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 32'h0,        2'b01, 2'b01, 2'b00, 1, A0, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b10, 2'b00, 1, 1, 0, 32'h0,        2'b10, 2'b01, 2'b00, 1, A1, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        2'b00, 2'b10, 2'b00, 0, 0,  0, 2'b00, 0));
    // fill both slots, stall, free one, routing in push order
    vq.push_back(mk(0, 2'b01, 2'b00, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, A0, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b10, 2'b00, 1, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 1, A1, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 32'h0,        2'b00, 2'b01, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 1, 1, 32'h0,        2'b01, 2'b10, 2'b10, 1, A0, 0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        2'b00, 2'b01, 2'b00, 0, 0,  0, 2'b00, 0));
    // unexpected rvalid, reset mid-transaction, unexpected again
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  1, 2'b00, 0));
    vq.push_back(mk(0, 2'b10, 2'b00, 1, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 1, A1, 1, 2'b00, 0));
    vq.push_back(mk(1, 2'b11, 2'b00, 1, 1, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  1, 2'b00, 0));
    vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 0,  0, 2'b00, 0));

    @(posedge clk_i);
    #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].req, vq[i].lock, vq[i].gnt, vq[i].rv, vq[i].err, vq[i].rdata);
      #2;
      chk("h_gnt", 32'(h_gnt_o), 32'(vq[i].e_gnt));
      chk("h_rvalid", 32'(h_rvalid_o), 32'(vq[i].e_rv));
      chk("h_err", 32'(h_err_o), 32'(vq[i].e_err));
      chk("h_rdata", h_rdata_o, vq[i].rst ? 32'h0 : vq[i].rdata);
      chk("unexp", 32'(unexp_rvalid_o), 32'(vq[i].e_unexp));
      chk_addr_phase(vq[i].e_req, vq[i].e_addr);
      if (vq[i].chk_fp) chk("fp_gnt", 32'(fp_gnt), 32'(vq[i].e_fpg));
      next_cycle();
    end

    // held owner drops its request: hold releases, next cycle arbitrates fresh (rr=host 0)
    drive(0, 2'b10, 2'b00, 0, 0, 0, 32'h0); #2;
    chk("hold_set_gnt", 32'(h_gnt_o), 32'(2'b00));
    chk_addr_phase(1'b1, A1);
    next_cycle();
    drive(0, 2'b01, 2'b00, 0, 0, 0, 32'h0); #2;
    chk("hold_drop_gnt", 32'(h_gnt_o), 32'(2'b00));
    chk_addr_phase(1'b0, 32'h0);
    next_cycle();
    drive(0, 2'b11, 2'b01, 1, 0, 0, 32'h0); #2;
    chk("hold_clr_gnt", 32'(h_gnt_o), 32'(2'b01));
    chk_addr_phase(1'b1, A0);
    next_cycle();

    // lock owner idles one cycle: lock releases, host 1 then wins on rr
    drive(0, 2'b00, 2'b00, 0, 1, 0, 32'h0); #2;
    chk("lock_idle_rv", 32'(h_rvalid_o), 32'(2'b01));
    next_cycle();
    drive(0, 2'b11, 2'b00, 1, 0, 0, 32'h0); #2;
    chk("lock_clr_gnt", 32'(h_gnt_o), 32'(2'b10));
    chk_addr_phase(1'b1, A1);
    next_cycle();
    drive(0, 2'b00, 2'b00, 0, 1, 1, 32'h5A5A5A5A); #2;
    chk("lock_clr_rv", 32'(h_rvalid_o), 32'(2'b10));
    chk("lock_clr_err", 32'(h_err_o), 32'(2'b10));
    chk("lock_clr_rdata", h_rdata_o, 32'h5A5A5A5A);
    next_cycle();

    drive(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
